// File: rtl/pipe_stage_chain.sv
// Elastic register chain of DEPTH slots carrying an opaque WIDTH-bit payload with valid/ready, stall, flush and bubble collapse.
// Optional PIPE_PERF_EN adds saturating stall/kill counters with a synchronous clear.
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(32'h00000013)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       stall,
  input  logic                       flush,
`ifdef PIPE_PERF_EN
  input  logic                       perf_clr,
  output logic [15:0]                stall_cnt,
  output logic [15:0]                kill_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] vld_nxt;
  logic [WIDTH-1:0] dat [DEPTH];
  logic             fire_in;
  logic             fire_out;

  function automatic logic [OW-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [OW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + OW'(v[i]);
    return c;
  endfunction

  assign out_valid = vld[DEPTH-1] & ~stall & ~flush;
  assign out_data  = dat[DEPTH-1];
  assign fire_out  = out_valid & out_ready;

  // A payload moves whenever the slot ahead is empty or emptying, so bubbles collapse.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = fire_out;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = vld[i] & (~vld[i+1] | adv[i+1]);
    end
  end

  assign in_ready = ~rst & ~stall & ~flush & (~vld[0] | adv[0]);
  assign fire_in  = in_valid & in_ready;

  always_comb begin
    vld_nxt = '0;
    vld_nxt[0] = fire_in | (vld[0] & ~adv[0]);
    for (int i = 1; i < DEPTH; i++) begin
      vld_nxt[i] = adv[i-1] | (vld[i] & ~adv[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld       <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= BUBBLE_VAL;
    end else if (flush) begin
      vld       <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) dat[i] <= BUBBLE_VAL;
    end else if (!stall) begin
      vld       <= vld_nxt;
      occupancy <= popcnt(vld_nxt);
      if (fire_in) dat[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i-1]) dat[i] <= dat[i-1];
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [16:0] kill_sum;
  assign kill_sum = {1'b0, kill_cnt} + 17'(popcnt(vld));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      if (stall && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (flush) kill_cnt <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain at DEPTH=3: ordering, latency, backpressure, collapse, stall, flush and reset.
module tb_pipe_stage_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             stall;
  logic             flush;
  logic [1:0]       occupancy;
`ifdef PIPE_PERF_EN
  logic             perf_clr;
  logic [15:0]      stall_cnt;
  logic [15:0]      kill_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q [$];

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall(stall), .flush(flush),
`ifdef PIPE_PERF_EN
    .perf_clr(perf_clr), .stall_cnt(stall_cnt), .kill_cnt(kill_cnt),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are judged mid-cycle, before the edge that commits them.
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("sb_data", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic drain(input string tag);
    logic ok;
    ok = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (occupancy == 2'd0 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
`ifdef PIPE_PERF_EN
    perf_clr = 1'b0;
`endif
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_data", out_data, 32'h13);
    check("rst_occ", {30'd0, occupancy}, 32'd0);
    step(); step();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming latency and back-to-back output.
    step();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hA; step();
    in_data = 32'hB; step();
    @(negedge clk);
    check("lat_not_yet", {31'd0, out_valid}, 32'd0);
    in_data = 32'hC; step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_occ_peak", {30'd0, occupancy}, 32'd3);
    step(); @(negedge clk);
    check("b2b_1", {31'd0, out_valid}, 32'd1);
    step(); @(negedge clk);
    check("b2b_2", {31'd0, out_valid}, 32'd1);
    step(); @(negedge clk);
    check("b2b_done", {31'd0, out_valid}, 32'd0);
    drain("drain_stream");

    // Full chain with backpressure, then pass-through.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h21; step();
    in_data = 32'h22; step();
    in_data = 32'h23; step();
    in_data = 32'h24;
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_occ", {30'd0, occupancy}, 32'd3);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("pass_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("pass_occ", {30'd0, occupancy}, 32'd3);
    drain("drain_full");

    // Bubble collapse toward the output end.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1; step();
    in_valid = 1'b0; step(); step();
    in_valid = 1'b1; in_data = 32'h2; step();
    in_valid = 1'b0; step(); step();
    @(negedge clk);
    check("collapse_occ", {30'd0, occupancy}, 32'd2);
    check("collapse_head", out_data, 32'h1);
    out_ready = 1'b1;
    step(); @(negedge clk);
    check("collapse_consec", {31'd0, out_valid}, 32'd1);
    check("collapse_second", out_data, 32'h2);
    drain("drain_collapse");

    // Stall freezes everything.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5; step();
    in_data = 32'h6; step();
    in_valid = 1'b0; step(); step();
    stall = 1'b1; in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd0);
      check("stall_occ", {30'd0, occupancy}, 32'd2);
      check("stall_head", out_data, 32'h5);
      step();
    end
    stall = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("unstall_valid", {31'd0, out_valid}, 32'd1);
    check("unstall_data", out_data, 32'h5);
    drain("drain_stall");

    // Flush with stall kills three slots and drops the flush-cycle input.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h31; step();
    in_data = 32'h32; step();
    in_data = 32'h33; step();
    flush = 1'b1; stall = 1'b1; in_data = 32'h77;
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_occ", {30'd0, occupancy}, 32'd0);
    check("flush_out_data", out_data, 32'h13);
`ifdef PIPE_PERF_EN
    check("kill_cnt", {16'd0, kill_cnt}, 32'd3);
    check("stall_cnt", {16'd0, stall_cnt}, 32'd4);
    perf_clr = 1'b1; step(); perf_clr = 1'b0;
    check("clr_kill", {16'd0, kill_cnt}, 32'd0);
    check("clr_stall", {16'd0, stall_cnt}, 32'd0);
`endif
    out_ready = 1'b1;
    step(); step(); step(); step();
    check("flush_no_ghost", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h41; step();
    in_data = 32'h42; step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    check("arst_occ", {30'd0, occupancy}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h51; step();
    in_data = 32'h52; step();
    drain("drain_after_rst");

    check("sb_left", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
